// File: rtl/dispatch_sequencer_pkg.sv
// dispatch_sequencer_pkg
//   Shared types and constants for the dispatch sequencer:
//   - seq_state_t  : dispatch FSM states
//   - opcode_t     : coarse instruction classes seen by predecode
//   - bit-pattern constants for LDP/STP/LDUR/STUR/HLT/BR/BLR/RET
//   - classify()   : maps a 32-bit instruction word to an opcode_t
package dispatch_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PAIR2   = 2'd1,
    WAIT_BR = 2'd2,
    HALTED  = 2'd3
  } seq_state_t;

  typedef enum logic [3:0] {
    OPC_OTHER = 4'd0,
    OPC_LDP   = 4'd1,
    OPC_STP   = 4'd2,
    OPC_LDUR  = 4'd3,
    OPC_STUR  = 4'd4,
    OPC_HLT   = 4'd5,
    OPC_BR    = 4'd6,
    OPC_BLR   = 4'd7,
    OPC_RET   = 4'd8
  } opcode_t;

  // Paired load/store: bits[31:22]
  localparam logic [9:0]  LDP_OP  = 10'b1010100011;
  localparam logic [9:0]  STP_OP  = 10'b1010100100;
  // Unscaled load/store: bits[31:21], with bits[11:10] == 2'b00
  localparam logic [10:0] LDUR_OP = 11'b11111000010;
  localparam logic [10:0] STUR_OP = 11'b11111000000;
  localparam logic [1:0]  UR_SUB  = 2'b00;
  // Halt: bits[31:21], with bits[4:0] == 0
  localparam logic [10:0] HLT_OP  = 11'b11010100010;
  // Indirect branches: bits[31:10], with bits[4:0] == 0
  localparam logic [21:0] BR_OP   = 22'b1101011000011111000000;
  localparam logic [21:0] BLR_OP  = 22'b1101011000111111000000;
  localparam logic [21:0] RET_OP  = 22'b1101011001011111000000;
  localparam logic [4:0]  RD_ZERO = 5'b00000;

  // The patterns are mutually exclusive, so the order of tests only
  // matters for readability.
  function automatic opcode_t classify(input logic [31:0] insn);
    opcode_t op;
    op = OPC_OTHER;
    if (insn[31:22] == LDP_OP) begin
      op = OPC_LDP;
    end else if (insn[31:22] == STP_OP) begin
      op = OPC_STP;
    end else if ((insn[31:21] == LDUR_OP) && (insn[11:10] == UR_SUB)) begin
      op = OPC_LDUR;
    end else if ((insn[31:21] == STUR_OP) && (insn[11:10] == UR_SUB)) begin
      op = OPC_STUR;
    end else if ((insn[31:21] == HLT_OP) && (insn[4:0] == RD_ZERO)) begin
      op = OPC_HLT;
    end else if ((insn[31:10] == BR_OP) && (insn[4:0] == RD_ZERO)) begin
      op = OPC_BR;
    end else if ((insn[31:10] == BLR_OP) && (insn[4:0] == RD_ZERO)) begin
      op = OPC_BLR;
    end else if ((insn[31:10] == RET_OP) && (insn[4:0] == RD_ZERO)) begin
      op = OPC_RET;
    end else begin
      op = OPC_OTHER;
    end
    return op;
  endfunction

endpackage

// File: rtl/dispatch_sequencer_predecode_class.sv
// predecode_class
//   Combinational predecode of the FIFO head instruction.
//   Ports:
//     insn    in   instruction bits [31:0]
//     is_pair out  LDP/STP (cracked into two micro-ops)
//     is_ls   out  routed to the LS reservation station
//     is_hlt  out  halt instruction
//     is_ind  out  indirect branch (BR/BLR/RET)
module predecode_class
  import dispatch_sequencer_pkg::*;
(
  input  logic [31:0] insn,
  output logic        is_pair,
  output logic        is_ls,
  output logic        is_hlt,
  output logic        is_ind
);

  opcode_t op_s;

  // Map the opcode class onto the four steering flags
  always_comb begin
    op_s    = classify(insn);
    is_pair = 1'b0;
    is_ls   = 1'b0;
    is_hlt  = 1'b0;
    is_ind  = 1'b0;
    case (op_s)
      OPC_LDP, OPC_STP: begin
        is_pair = 1'b1;
        is_ls   = 1'b1;
      end
      OPC_LDUR, OPC_STUR: begin
        is_ls = 1'b1;
      end
      OPC_HLT: begin
        is_hlt = 1'b1;
      end
      OPC_BR, OPC_BLR, OPC_RET: begin
        is_ind = 1'b1;
      end
      default: begin
        is_pair = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dispatch_sequencer.sv
// dispatch_sequencer
//   Buffers fetched instructions in a DEPTH-entry FIFO and releases one
//   micro-op per cycle to decode when the ROB and the target reservation
//   station can accept it. LDP/STP are cracked into two micro-ops that
//   share the head entry; dispatch pauses after an indirect branch until
//   it resolves, and stops for good after HLT.
//   Ports:
//     in_clk, in_rst_n              clock, async active-low reset
//     in_fetch_valid/insnbits/pc    fetch push request
//     out_fetch_ready               FIFO accepts a push this cycle
//     in_flush                      kill all buffered work
//     in_br_resolved                outstanding indirect branch resolved
//     in_rob_ready, in_rs_*_ready   downstream capacity
//     out_dec_valid/insnbits/pc     head micro-op presented to decode
//     out_dec_uop_idx               0 = first/only, 1 = second pair half
//     out_dec_fire                  micro-op accepted this cycle
//     out_stalled                   head blocked or waiting on a branch
//     out_halted                    HLT has been dispatched
module dispatch_sequencer
  import dispatch_sequencer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 64,
  parameter int INSN_W = 32
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_fetch_valid,
  input  logic [INSN_W-1:0] in_fetch_insnbits,
  input  logic [PC_W-1:0]   in_fetch_pc,
  output logic              out_fetch_ready,
  input  logic              in_flush,
  input  logic              in_br_resolved,
  input  logic              in_rob_ready,
  input  logic              in_rs_alu_ready,
  input  logic              in_rs_ls_ready,
  output logic              out_dec_valid,
  output logic [INSN_W-1:0] out_dec_insnbits,
  output logic [PC_W-1:0]   out_dec_pc,
  output logic              out_dec_uop_idx,
  output logic              out_dec_fire,
  output logic              out_stalled,
  output logic              out_halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSN_W-1:0] insn_mem_r [DEPTH];
  logic [PC_W-1:0]   pc_mem_r   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  seq_state_t        state_r;
  logic              halted_r;

  logic              full_s;
  logic              empty_s;
  logic              flush_s;
  logic              fetch_ready_s;
  logic              push_s;
  logic              pop_s;
  logic              dec_valid_s;
  logic              rs_ready_s;
  logic              fire_s;
  logic [INSN_W-1:0] head_insn_s;
  logic [PC_W-1:0]   head_pc_s;
  logic              is_pair_s;
  logic              is_ls_s;
  logic              is_hlt_s;
  logic              is_ind_s;

  assign full_s      = (count_r == CNT_W'(DEPTH));
  assign empty_s     = (count_r == CNT_W'(0));
  assign head_insn_s = insn_mem_r[rd_ptr_r];
  assign head_pc_s   = pc_mem_r[rd_ptr_r];

  // A halted sequencer ignores flush: only reset leaves HALTED.
  assign flush_s = in_flush & (state_r != HALTED);

  // Ready is held low during reset so fetch never pushes into a FIFO
  // that is being cleared. No push while full, even alongside a pop.
  assign fetch_ready_s = in_rst_n & ~full_s & (state_r != HALTED) & ~in_flush;
  assign push_s        = in_fetch_valid & fetch_ready_s;

  predecode_class u_predecode (
    .insn    (head_insn_s[31:0]),
    .is_pair (is_pair_s),
    .is_ls   (is_ls_s),
    .is_hlt  (is_hlt_s),
    .is_ind  (is_ind_s)
  );

  assign dec_valid_s = ~empty_s & ~in_flush & ((state_r == RUN) | (state_r == PAIR2));
  assign rs_ready_s  = is_ls_s ? in_rs_ls_ready : in_rs_alu_ready;
  assign fire_s      = dec_valid_s & in_rob_ready & rs_ready_s;
  // The first half of a pair leaves the entry at the head for the second.
  assign pop_s       = fire_s & ~((state_r == RUN) & is_pair_s);

  assign out_fetch_ready  = fetch_ready_s;
  assign out_dec_valid    = dec_valid_s;
  assign out_dec_insnbits = head_insn_s;
  assign out_dec_pc       = head_pc_s;
  assign out_dec_uop_idx  = (state_r == PAIR2);
  assign out_dec_fire     = fire_s;
  assign out_stalled      = (state_r == WAIT_BR) | (dec_valid_s & ~fire_s);
  assign out_halted       = halted_r;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        insn_mem_r[i] <= '0;
        pc_mem_r[i]   <= '0;
      end
    end else if (flush_s) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) begin
        insn_mem_r[wr_ptr_r] <= in_fetch_insnbits;
        pc_mem_r[wr_ptr_r]   <= in_fetch_pc;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Dispatch sequencing FSM with registered halt flag
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_r  <= RUN;
      halted_r <= 1'b0;
    end else if (flush_s) begin
      state_r <= RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (fire_s && is_pair_s) begin
            state_r <= PAIR2;
          end else if (fire_s && is_hlt_s) begin
            state_r  <= HALTED;
            halted_r <= 1'b1;
          end else if (fire_s && is_ind_s) begin
            state_r <= WAIT_BR;
          end else begin
            state_r <= RUN;
          end
        end
        PAIR2: begin
          if (fire_s) begin
            state_r <= RUN;
          end else begin
            state_r <= PAIR2;
          end
        end
        WAIT_BR: begin
          if (in_br_resolved) begin
            state_r <= RUN;
          end else begin
            state_r <= WAIT_BR;
          end
        end
        HALTED: begin
          state_r <= HALTED;
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/dispatch_sequencer.md
Name: dispatch_sequencer

Overview:
Sits between fetch and the decode/dispatch stage. It buffers fetched instructions in a small FIFO and releases one micro-op per cycle to decode when the ROB and the target reservation station (ALU or LS) can accept it. Paired memory ops (LDP/STP) are cracked into two micro-ops. Dispatch is serialised behind indirect branches (BR/BLR/RET) and stops permanently on HLT.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
PC_W, 64, PC width
INSN_W, 32, instruction width

Ports:
in_clk  in  1  clock
in_rst_n  in  1  asynchronous active-low reset
in_fetch_valid  in  1  fetch offers an instruction
in_fetch_insnbits  in  INSN_W  instruction bits
in_fetch_pc  in  PC_W  instruction PC
out_fetch_ready  out  1  FIFO accepts a push this cycle
in_flush  in  1  mispredict/redirect from commit; kill all buffered work
in_br_resolved  in  1  outstanding indirect branch has resolved
in_rob_ready  in  1  ROB has a free slot
in_rs_alu_ready  in  1  ALU reservation station has a free slot
in_rs_ls_ready  in  1  LS reservation station has a free slot
out_dec_valid  out  1  head micro-op is presented to decode
out_dec_insnbits  out  INSN_W  head instruction bits
out_dec_pc  out  PC_W  head PC
out_dec_uop_idx  out  1  0 = first (or only) micro-op, 1 = second half of pair
out_dec_fire  out  1  micro-op is accepted this cycle
out_stalled  out  1  head valid but not dispatched, or waiting on a branch
out_halted  out  1  HLT has been dispatched

Behaviour:
- Reset (in_rst_n low, async) sets the following:
  - count=0, read/write pointers=0, state=RUN, out_halted=0.
  - out_fetch_ready is forced to 0 while reset is asserted.
  - All other outputs are 0.
- FIFO:
  - push = in_fetch_valid & out_fetch_ready.
  - out_fetch_ready = ~full & state!=HALTED & ~in_flush.
  - There is no push-when-full, even if a pop happens in the same cycle.
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
  - There is no bypass: an entry pushed in cycle N is at the head no earlier than cycle N+1.
  - Simultaneous push and pop leaves count unchanged.
- Predecode of the head entry (combinational):
  - is_pair: bits[31:22] = 1010100011 (LDP) or 1010100100 (STP).
  - is_ls: is_pair, or bits[31:21] = 11111000010 / 11111000000 with bits[11:10] = 00 (LDUR/STUR).
  - is_hlt: bits[31:21] = 11010100010 and bits[4:0] = 0.
  - is_ind: bits[31:10] = 1101011000x11111000000 (BR/BLR) or 1101011001011111000000 (RET), with bits[4:0] = 0.
- out_dec_valid = ~empty & ~in_flush & state in {RUN, PAIR2}.
- fire = out_dec_valid & in_rob_ready & (is_ls ? in_rs_ls_ready : in_rs_alu_ready).
- out_dec_* fields are combinational from the FIFO head; the decode stage registers them.
- State machine:
  - RUN, fire & is_pair: emit uop_idx=0, no pop, go to PAIR2.
  - RUN, fire & is_hlt: pop, go to HALTED.
  - RUN, fire & is_ind: pop, go to WAIT_BR.
  - RUN, fire otherwise: pop, stay in RUN.
  - PAIR2, fire: emit uop_idx=1, pop, go to RUN. The same head entry and PC are presented for both halves.
  - WAIT_BR: out_dec_valid=0. in_br_resolved goes to RUN.
  - HALTED: terminal. out_halted=1, no dispatch, no fetch. Exited only by reset.
- Flush:
  - in_flush has priority over every other event.
  - It takes effect in any state except HALTED: count=0, pointers=0, state=RUN.
  - A push in the flush cycle is dropped.
  - Flush with in_br_resolved in the same cycle behaves as flush alone.
  - Flush during PAIR2 discards the second half.
- out_stalled = (state==WAIT_BR) | (out_dec_valid & ~fire).
- in_br_resolved outside WAIT_BR is ignored.
- Reset asserted mid-pair or mid-wait returns immediately to the reset state; there are no partial effects.

Decomposition:
- Shared package:
  - seq_state_t enum (RUN, PAIR2, WAIT_BR, HALTED).
  - Predecode bit-pattern constants for LDP, STP, LDUR, STUR, HLT, BR, BLR, RET, kept alongside the existing opcode_t definitions.
- Sub-module predecode_class: combinational, takes insnbits and outputs is_pair, is_ls, is_hlt, is_ind.
- FIFO storage and the FSM live in the top module.

Test Plan:
- Basic flow: push ADD 0x91000420 at PC 0x1000 with all readies high -> out_dec_valid rises the next cycle with pc=0x1000 and uop_idx=0; fire pops it; count returns to 0.
- Pair cracking: push LDP 0xA8C00000 with in_rs_ls_ready=1 -> two fire cycles with the same pc, uop_idx 0 then 1; single pop; a following ADD dispatches on the third cycle.
- Backpressure: fill DEPTH=4 entries with in_rob_ready=0 -> out_fetch_ready=0 once count=4, out_stalled=1; raise in_rob_ready -> ready returns after the first pop.
- RS routing: STUR 0xF8000020 at head with in_rs_ls_ready=0 and in_rs_alu_ready=1 -> no fire, out_stalled=1; raise ls_ready -> fire.
- Indirect serialisation: RET 0xD65F03C0 followed by ADD -> RET fires, then out_dec_valid=0 until in_br_resolved pulses; the ADD fires the cycle after. Repeat with in_flush in place of resolve -> ADD discarded, count=0.
- Halt, flush-in-pair and async reset:
  - HLT 0xD4400000 -> out_halted=1 after fire; out_fetch_ready=0; in_flush ignored.
  - in_flush during PAIR2 -> no uop_idx=1 emitted.
  - in_rst_n low mid-pair -> immediate return to reset values.
